// File: rtl/mc_port_responder.sv
// mc_port_responder: single-port MC responder model with in-order responses, backpressure and flush
module mc_port_responder #(
    parameter int RTNCTL_WIDTH = 32,
    parameter int ADDR_W       = 10,
    parameter int LAT          = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    mc_rq_vld,
    input  logic [2:0]              mc_rq_cmd,
    input  logic [3:0]              mc_rq_scmd,
    input  logic [1:0]              mc_rq_size,
    input  logic [47:0]             mc_rq_vadr,
    input  logic [63:0]             mc_rq_data,
    input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic                    mc_rq_flush,
    output logic                    mc_rq_stall,
    output logic                    mc_rs_vld,
    output logic [2:0]              mc_rs_cmd,
    output logic [3:0]              mc_rs_scmd,
    output logic [63:0]             mc_rs_data,
    output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic                    mc_rs_stall,
    output logic                    mc_rs_flush_cmplt,
    output logic                    o_err_drop,
    output logic                    o_err_cmd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] OCC_HI   = OW'(FIFO_DEPTH - 2);
    localparam logic [2:0] CMD_RD = 3'd1;
    localparam logic [2:0] CMD_WR = 3'd2;
    localparam logic [2:0] RS_RD  = 3'd2;
    localparam logic [2:0] RS_WR  = 3'd3;

    logic [63:0]             mem [2**ADDR_W];
    logic [OW-1:0]           occ;
    logic [ADDR_W-1:0]       idx;
    logic                    is_wr, cmd_ok, accept, push, pop, empty, flush_pend;
    logic [LAT-1:0]          p_vld;
    logic [2:0]              p_cmd  [LAT];
    logic [63:0]             p_data [LAT];
    logic [RTNCTL_WIDTH-1:0] p_rt   [LAT];
    logic [2:0]              f_cmd  [FIFO_DEPTH];
    logic [63:0]             f_data [FIFO_DEPTH];
    logic [RTNCTL_WIDTH-1:0] f_rt   [FIFO_DEPTH];
    logic [OW-1:0]           wr_ptr, rd_ptr;
    logic                    unused_in;

    assign mc_rs_scmd = 4'd0;
    assign unused_in  = ^{mc_rq_scmd, mc_rq_size, mc_rq_vadr[47:ADDR_W+3], mc_rq_vadr[2:0]};

    // request decode, FIFO status and request backpressure from registered occupancy
    always_comb begin
        idx         = mc_rq_vadr[ADDR_W+2:3];
        is_wr       = mc_rq_cmd == CMD_WR;
        cmd_ok      = mc_rq_cmd == CMD_RD || is_wr;
        accept      = mc_rq_vld && cmd_ok && occ < OCC_FULL;
        push        = p_vld[LAT-1];
        empty       = wr_ptr == rd_ptr;
        pop         = !mc_rs_stall && !empty;
        mc_rq_stall = occ >= OCC_HI;
    end

    // backing store; not reset so contents survive reset
    always_ff @(posedge clk) begin
        if (accept && is_wr)
            mem[idx] <= mc_rq_data;
    end

    // pipeline valid tags; cleared on reset so in-flight requests vanish
    always_ff @(posedge clk) begin
        if (i_reset) begin
            p_vld <= '0;
        end else begin
            p_vld[0] <= accept;
            for (int i = 1; i < LAT; i++)
                p_vld[i] <= p_vld[i-1];
        end
    end

    // pipeline payload; read data sampled before this edge's memory write takes effect
    always_ff @(posedge clk) begin
        p_cmd[0]  <= is_wr ? RS_WR : RS_RD;
        p_data[0] <= is_wr ? 64'd0 : mem[idx];
        p_rt[0]   <= mc_rq_rtnctl;
        for (int i = 1; i < LAT; i++) begin
            p_cmd[i]  <= p_cmd[i-1];
            p_data[i] <= p_data[i-1];
            p_rt[i]   <= p_rt[i-1];
        end
    end

    // response FIFO storage, written from the last pipeline stage
    always_ff @(posedge clk) begin
        if (push) begin
            f_cmd[wr_ptr[PW-1:0]]  <= p_cmd[LAT-1];
            f_data[wr_ptr[PW-1:0]] <= p_data[LAT-1];
            f_rt[wr_ptr[PW-1:0]]   <= p_rt[LAT-1];
        end
    end

    // FIFO pointers and occupancy; occ covers pipeline plus FIFO so the FIFO never overflows
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + OW'(accept) - OW'(pop);
        end
    end

    // output register; fields hold when nothing is popped
    always_ff @(posedge clk) begin
        if (i_reset) begin
            mc_rs_vld    <= 1'b0;
            mc_rs_cmd    <= '0;
            mc_rs_data   <= '0;
            mc_rs_rtnctl <= '0;
        end else begin
            mc_rs_vld <= pop;
            if (pop) begin
                mc_rs_cmd    <= f_cmd[rd_ptr[PW-1:0]];
                mc_rs_data   <= f_data[rd_ptr[PW-1:0]];
                mc_rs_rtnctl <= f_rt[rd_ptr[PW-1:0]];
            end
        end
    end

    // flush tracking (merging pending flushes) and sticky error flags
    always_ff @(posedge clk) begin
        if (i_reset) begin
            flush_pend        <= 1'b0;
            mc_rs_flush_cmplt <= 1'b0;
            o_err_drop        <= 1'b0;
            o_err_cmd         <= 1'b0;
        end else begin
            mc_rs_flush_cmplt <= flush_pend && occ == '0;
            flush_pend        <= (flush_pend && occ != '0) || mc_rq_flush;
            o_err_drop        <= o_err_drop || (mc_rq_vld && occ == OCC_FULL);
            o_err_cmd         <= o_err_cmd || (mc_rq_vld && !cmd_ok);
        end
    end
endmodule
